barrel_shift_right_seq: RTL

- Multi-cycle 32-bit right shifter for the full ALU, complementing the combinational left barrel shifter. It covers SRL (logical) and SRA (arithmetic) operations.
- Resolves one amount bit per clock: 5 log-stages, stage i shifts by 2^i.
- Start/ready/done handshake, so the ALU control can stall while the shift completes.

---
 rtl/barrel_shift_right_seq_if.sv | 38 +++
 rtl/barrel_shift_right_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/barrel_shift_right_seq_if.sv
// rtl/barrel_shift_right_seq_if.sv - start/ready/done handshake bundle for the sequential right shifter
interface barrel_shift_right_seq_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
);
    logic              start;
    logic [WIDTH-1:0]  A;
    logic [STAGES-1:0] amt;
    logic              arith;
    logic              ready;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  Out;

    // ALU control side: issues operations, watches completion
    modport master (
        output start,
        output A,
        output amt,
        output arith,
        input  ready,
        input  busy,
        input  done,
        input  Out
    );

    // Shifter side: accepts operations, reports completion
    modport slave (
        input  start,
        input  A,
        input  amt,
        input  arith,
        output ready,
        output busy,
        output done,
        output Out
    );
endinterface

// File: rtl/barrel_shift_right_seq.sv
// rtl/barrel_shift_right_seq.sv - multi-cycle 32-bit SRL/SRA shifter, one amount bit per clock
module barrel_shift_right_seq #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    barrel_shift_right_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);

    state_t            state;
    logic [WIDTH-1:0]  w;
    logic [WIDTH-1:0]  out_reg;
    logic [STAGES-1:0] amt_reg;
    logic              arith_reg;
    logic [2:0]        stage;
    logic              ready_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [STAGES-1:0] step;
    logic [WIDTH-1:0]  fill_mask;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  w_next;
    logic              stage_bit;

    // One log-stage: shift W by 2^stage, filling vacated MSBs with the sign
    // when arithmetic. W[31] is stable under SRA, so it equals the original A[31].
    always_comb begin
        step      = {{(STAGES - 1){1'b0}}, 1'b1} << stage;
        fill_mask = ~({WIDTH{1'b1}} >> step);
        shifted   = (w >> step) | ((arith_reg && w[WIDTH-1]) ? fill_mask : '0);
        stage_bit = amt_reg[stage];
        w_next    = stage_bit ? shifted : w;
    end

    // Control FSM with registered handshake outputs; a start is honoured only
    // in IDLE or DONE, so requests made while shifting are simply dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            w         <= '0;
            out_reg   <= '0;
            amt_reg   <= '0;
            arith_reg <= 1'b0;
            stage     <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        w         <= bus.A;
                        amt_reg   <= bus.amt;
                        arith_reg <= bus.arith;
                        stage     <= '0;
                        state     <= S_SHIFT;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    w     <= w_next;
                    stage <= stage + 3'd1;
                    if (stage == LAST_STAGE) begin
                        out_reg   <= w_next;
                        state     <= S_DONE;
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.Out   = out_reg;

endmodule
